ddl_dtc_rdo_sequencer: RTL
==========================

Name: ddl_dtc_rdo_sequencer

Overview:
- Downstream consumer of the 40-DTC front-end partition. It drains that partition's per-DTC event RAMs into a single DDL word stream.
- Once the all-channels event-ready flag is seen, it walks channels 0..39 in order and skips masked channels.
- For each channel it emits a header word followed by the payload words, then closes the event with a trailer word and a one-cycle read-confirm pulse.
- All RAM-port signalling matches the partition's RAM port B: one-hot enable, shared 10-bit address, 40x33-bit data bus.

Parameters:
- NCH, 40, number of DTC channels.
- HDR_MARK, 6'h3A, bits [31:26] of the trailer marker field (trailer = {1'b1, HDR_MARK, 9'h0, count}).

Ports:
- DtcRamclkb input 1: single clock for the whole block and the RAM read port.
- reset_n input 1: asynchronous, active-low reset.
- DtcRamFlag input 1: all unmasked channels hold a complete event.
- DtcRamClr input 1: abort/clear request (level).
- dtc_mask input 40: 1 = channel excluded (equals rdo_cfg[39:0]).
- rdo_en input 1: readout enable.
- DtcRamenb output 40: one-hot RAM read enable.
- DtcRamaddrb output 10: RAM read address.
- DtcRamdoutb input 1320: channel j data at [33j+32:33j].
- DtcRamReadConfirm output 1: one-cycle pulse at event end.
- ddl_data output 33: output word.
- ddl_valid output 1: ddl_data is valid.
- ddl_ready input 1: sink accepts the word (driven as ~|ddl_xoff).
- rdo_busy output 1: high whenever the FSM is not in IDLE.
- evt_cnt output 16: completed events, wraps at 16'hFFFF->0.
- abort_cnt output 8: aborted events, saturates at 8'hFF.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, internal buffers empty.
- RAM format per channel:
  - Address 0: bits [9:0] = payload length L (0..1023).
  - Addresses 1..L: payload.
  - Read latency: data is valid on DtcRamdoutb exactly 1 cycle after DtcRamenb/DtcRamaddrb are presented.
- Handshake: a word transfers on a clock edge where ddl_valid && ddl_ready. While ddl_valid=1 and ddl_ready=0, ddl_data is held stable. No word is dropped or duplicated.
- Skid buffer: a 2-entry buffer absorbs the 1-cycle RAM latency. A new RAM read is issued only when the buffer holds fewer than 2 words, counting reads still in flight.
- FSM states and transitions:
  - IDLE: go to SEL when DtcRamFlag && rdo_en && !DtcRamClr. Channel index ch=0, word counter wc=0.
  - SEL: if ch==NCH go to TRL. Else if dtc_mask[ch]=1, do ch+1 and stay in SEL (one cycle per masked channel). Else go to HRD.
  - HRD: drive address 0 with DtcRamenb[ch]=1 for one cycle, then go to HWT.
  - HWT: capture L. Push header {1'b1, ch[5:0], 16'h0, L} (bit32=1, [31:26]=ch, [9:0]=L). Go to PAY if L>0, else do ch+1 and go to SEL.
  - PAY: issue reads at addresses 1..L, rate-limited by the skid buffer. Each word is forwarded unchanged (all 33 bits). When the last payload word has been pushed, do ch+1 and go to SEL.
  - TRL: push trailer {1'b1, HDR_MARK, 9'h0, wc[16:0] truncated to 17 bits}. wc counts every word transferred (header + payload) in this event. When the trailer transfers, go to CNF.
  - CNF: DtcRamReadConfirm=1 for exactly one cycle, evt_cnt+1, go to WAITLOW.
  - WAITLOW: go to IDLE when DtcRamFlag=0, so one event is never read twice.
- DtcRamenb is all-zero outside HRD and outside PAY read-issue cycles.
- All channels masked: the event is just the trailer with count=0, followed by the confirm pulse.
- Abort: DtcRamClr=1 in any state other than IDLE has priority over every other transition.
  - Next edge: ddl_valid=0, buffer flushed, DtcRamenb=0, FSM to IDLE.
  - No confirm pulse is issued; abort_cnt+1.
- rdo_en dropping mid-event does not stop the event; it only gates the next start.
- Width rule: L is taken from bits [9:0] only; bits [32:10] of address 0 are ignored.

Test Plan:
- Channels 0 and 5 unmasked (L=3 and L=0), all others masked, ddl_ready=1 -> output is hdr(ch0,L=3), 3 payload words, hdr(ch5,L=0), trailer count=5; one DtcRamReadConfirm pulse; evt_cnt=1.
- dtc_mask=40'hFFFFFFFFFF with DtcRamFlag=1 -> only the trailer with count 0 is output, then the confirm pulse; DtcRamenb is never asserted.
- Channel 39 only, L=1023, ddl_ready toggled by a random pattern -> 1024 words in address order with no loss or duplication; ddl_data is stable whenever valid is high and ready is low; trailer count=1024.
- DtcRamClr pulsed at payload word 10 of channel 2 -> ddl_valid=0 on the next cycle, no confirm pulse, abort_cnt=1, FSM in IDLE; a fresh flag then reads the full event correctly.
- DtcRamFlag held high after the confirm pulse -> no second event starts until the flag goes low and then high again.
- reset_n asserted mid-payload -> all outputs 0 immediately (asynchronously); after release, rdo_busy=0 and evt_cnt=0.

Source files
------------

// File: rtl/ddl_dtc_rdo_sequencer.sv
// rtl/ddl_dtc_rdo_sequencer.sv - drains the 40 per-DTC event RAMs into one DDL word stream
module ddl_dtc_rdo_sequencer #(
    parameter int         NCH      = 40,
    parameter logic [5:0] HDR_MARK = 6'h3A
) (
    input  logic                 DtcRamclkb,
    input  logic                 reset_n,
    input  logic                 DtcRamFlag,
    input  logic                 DtcRamClr,
    input  logic [NCH-1:0]       dtc_mask,
    input  logic                 rdo_en,
    output logic [NCH-1:0]       DtcRamenb,
    output logic [9:0]           DtcRamaddrb,
    input  logic [33*NCH-1:0]    DtcRamdoutb,
    output logic                 DtcRamReadConfirm,
    output logic [32:0]          ddl_data,
    output logic                 ddl_valid,
    input  logic                 ddl_ready,
    output logic                 rdo_busy,
    output logic [15:0]          evt_cnt,
    output logic [7:0]           abort_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_HRD, S_HWT, S_PAY, S_TRL, S_CNF, S_WAITLOW
    } state_t;

    state_t         r_state;
    logic [5:0]     r_ch;
    logic [16:0]    r_wc;
    logic [9:0]     r_iss_left;
    logic [9:0]     r_pay_left;
    logic [9:0]     r_addr;
    logic [NCH-1:0] r_enb;
    logic           r_pay_rd;
    logic           r_pend;
    logic [32:0]    r_buf [0:1];
    logic           r_wr;
    logic           r_rd;
    logic [1:0]     r_cnt;
    logic           r_trl_pushed;
    logic           r_confirm;
    logic [15:0]    r_evt_cnt;
    logic [7:0]     r_abort_cnt;

    logic [32:0]    w_dout;
    logic [NCH-1:0] w_onehot;
    logic           w_pop;
    logic [2:0]     w_occ;
    logic           w_issue;
    logic           w_hdr_push;
    logic           w_trl_push;
    logic           w_trl_done;
    logic           w_push;
    logic [32:0]    w_push_data;
    logic           w_abort;

    always_comb begin
        w_dout = '0;
        for (int j = 0; j < NCH; j++) begin
            if (r_ch == 6'(j)) begin
                w_dout = DtcRamdoutb[33*j +: 33];
            end
        end
    end

    assign w_onehot = NCH'(1) << r_ch;
    assign w_pop    = (r_cnt != 2'd0) && ddl_ready;
    assign w_abort  = (r_state != S_IDLE) && DtcRamClr;

    // Occupancy after this edge including payload reads already presented or returning;
    // a new read is only issued if its word is guaranteed a slot when it lands.
    assign w_occ      = {1'b0, r_cnt} + {2'b0, r_pend} + {2'b0, r_pay_rd} - {2'b0, w_pop};
    assign w_issue    = (r_state == S_PAY) && (r_iss_left != 10'd0) && (w_occ < 3'd2);
    assign w_hdr_push = (r_state == S_HWT);
    assign w_trl_push = (r_state == S_TRL) && !r_trl_pushed && ((r_cnt != 2'd2) || w_pop);
    assign w_trl_done = (r_state == S_TRL) && r_trl_pushed && (r_cnt == 2'd1) && w_pop;
    assign w_push     = w_hdr_push || w_trl_push || r_pend;

    always_comb begin
        w_push_data = w_dout;
        if (w_hdr_push) begin
            w_push_data = {1'b1, r_ch, 16'h0, w_dout[9:0]};
        end else if (w_trl_push) begin
            w_push_data = {1'b1, HDR_MARK, 9'h0, r_wc};
        end
    end

    assign ddl_valid         = (r_cnt != 2'd0);
    assign ddl_data          = ddl_valid ? r_buf[r_rd] : 33'h0;
    assign DtcRamenb         = r_enb;
    assign DtcRamaddrb       = r_addr;
    assign DtcRamReadConfirm = r_confirm;
    assign rdo_busy          = (r_state != S_IDLE);
    assign evt_cnt           = r_evt_cnt;
    assign abort_cnt         = r_abort_cnt;

    always_ff @(posedge DtcRamclkb or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_wc         <= '0;
            r_iss_left   <= '0;
            r_pay_left   <= '0;
            r_addr       <= '0;
            r_enb        <= '0;
            r_pay_rd     <= 1'b0;
            r_pend       <= 1'b0;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_wr         <= 1'b0;
            r_rd         <= 1'b0;
            r_cnt        <= '0;
            r_trl_pushed <= 1'b0;
            r_confirm    <= 1'b0;
            r_evt_cnt    <= '0;
            r_abort_cnt  <= '0;
        end else begin
            r_confirm <= 1'b0;
            r_enb     <= '0;
            r_pay_rd  <= 1'b0;
            r_pend    <= r_pay_rd;

            if (w_abort) begin
                r_state      <= S_IDLE;
                r_cnt        <= '0;
                r_wr         <= 1'b0;
                r_rd         <= 1'b0;
                r_pend       <= 1'b0;
                r_trl_pushed <= 1'b0;
                if (r_abort_cnt != 8'hFF) begin
                    r_abort_cnt <= r_abort_cnt + 8'd1;
                end
            end else begin
                if (w_push) begin
                    r_buf[r_wr] <= w_push_data;
                    r_wr        <= ~r_wr;
                end
                if (w_pop) begin
                    r_rd <= ~r_rd;
                end
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};

                if (w_hdr_push || r_pend) begin
                    r_wc <= r_wc + 17'd1;
                end

                if (w_issue) begin
                    r_enb      <= w_onehot;
                    r_addr     <= r_addr + 10'd1;
                    r_iss_left <= r_iss_left - 10'd1;
                    r_pay_rd   <= 1'b1;
                end

                case (r_state)
                    S_IDLE: begin
                        if (DtcRamFlag && rdo_en && !DtcRamClr) begin
                            r_ch    <= '0;
                            r_wc    <= '0;
                            r_state <= S_SEL;
                        end
                    end
                    S_SEL: begin
                        if (r_ch == 6'(NCH)) begin
                            r_state <= S_TRL;
                        end else if (dtc_mask[r_ch]) begin
                            r_ch <= r_ch + 6'd1;
                        end else if (r_cnt != 2'd2) begin
                            // Header slot is reserved here: nothing else pushes before HWT.
                            r_enb   <= w_onehot;
                            r_addr  <= '0;
                            r_state <= S_HRD;
                        end
                    end
                    S_HRD: begin
                        r_state <= S_HWT;
                    end
                    S_HWT: begin
                        if (w_dout[9:0] != 10'd0) begin
                            r_iss_left <= w_dout[9:0];
                            r_pay_left <= w_dout[9:0];
                            r_state    <= S_PAY;
                        end else begin
                            r_ch    <= r_ch + 6'd1;
                            r_state <= S_SEL;
                        end
                    end
                    S_PAY: begin
                        if (r_pend) begin
                            r_pay_left <= r_pay_left - 10'd1;
                            if (r_pay_left == 10'd1) begin
                                r_ch    <= r_ch + 6'd1;
                                r_state <= S_SEL;
                            end
                        end
                    end
                    S_TRL: begin
                        if (w_trl_push) begin
                            r_trl_pushed <= 1'b1;
                        end
                        if (w_trl_done) begin
                            r_trl_pushed <= 1'b0;
                            r_confirm    <= 1'b1;
                            r_state      <= S_CNF;
                        end
                    end
                    S_CNF: begin
                        r_evt_cnt <= r_evt_cnt + 16'd1;
                        r_state   <= S_WAITLOW;
                    end
                    S_WAITLOW: begin
                        if (!DtcRamFlag) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
